// File: rtl/point_generator_pkg.sv
// Shared types and fixed-point constants for the Mandelbrot point generator.
// Default operand format is Q4.28; limits are expressed at full product width.
package point_generator_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ITERATE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int DATA_W_DEF    = 32;
    localparam int FRAC_BITS_DEF = 28;

    // |z|^2 escape bound: 4.0 in a 2*FRAC_BITS-fraction product
    function automatic logic [127:0] escape_limit(input int frac);
        return 128'd4 << (2 * frac);
    endfunction

    // Period-2 bulb radius squared: 1/16 in a 2*FRAC_BITS-fraction product
    function automatic logic [127:0] bulb_limit(input int frac);
        return 128'd1 << (2 * frac - 4);
    endfunction

    localparam logic [127:0] ESCAPE_LIMIT = escape_limit(FRAC_BITS_DEF);
    localparam logic [127:0] BULB_LIMIT   = bulb_limit(FRAC_BITS_DEF);

endpackage

// File: rtl/fxp_mul.sv
// Signed W x W -> 2W full-width multiplier.
// Combinational, no backpressure.
module fxp_mul
    import point_generator_pkg::*;
#(
    parameter int W = DATA_W_DEF
) (
    input  logic signed [W-1:0]   a,
    input  logic signed [W-1:0]   b,
    output logic signed [2*W-1:0] p
);

    assign p = a * b;

endmodule

// File: rtl/point_generator.sv
// Escape-time iteration count of one Mandelbrot point (optional bulb shortcut: POINT_GENERATOR_BULB_EN).
// Latency n+2 cycles from start (2 when the bulb shortcut hits); one z-update per cycle.
// No backpressure: start always wins and aborts any point in flight; ready holds until the next start.
module point_generator
    import point_generator_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF,
    parameter int COORD_W   = 12,
    parameter int ITER_W    = 32
) (
    input  logic                     CLK,
    input  logic                     SYS_RESET_N,
    input  logic                     start,
    input  logic [COORD_W-1:0]       x,
    input  logic [COORD_W-1:0]       y,
    input  logic [DATA_W-1:0]        re_scale,
    input  logic [DATA_W-1:0]        im_scale,
    input  logic signed [DATA_W-1:0] re_start,
    input  logic signed [DATA_W-1:0] im_start,
    input  logic [ITER_W-1:0]        max_iterations,
    output logic                     ready,
    output logic [ITER_W-1:0]        iteration
);

    localparam int W2 = 2 * DATA_W;
    localparam logic [W2:0] ESC_LIM = (W2+1)'(escape_limit(FRAC_BITS));

    state_t                    state;
    logic [COORD_W-1:0]        x_q, y_q;
    logic [DATA_W-1:0]         re_scale_q, im_scale_q;
    logic signed [DATA_W-1:0]  re_start_q, im_start_q;
    logic [ITER_W-1:0]         max_q;
    logic signed [DATA_W-1:0]  c_re, c_im, z_re, z_im;
    logic [ITER_W-1:0]         n;

    logic signed [DATA_W-1:0]  a0, a1, b0, b1;
    logic signed [W2-1:0]      prod_a, prod_b, prod_c, diff;
    logic signed [DATA_W-1:0]  c_re_next, c_im_next, re_next, im_next;
    logic [W2:0]               mag;
    logic                      escape, in_bulb, unused_bits;

    // Multipliers a/b are shared: pixel*scale in SETUP, zr^2/zi^2 while iterating.
    always_comb begin
        a0 = z_re;
        a1 = z_re;
        b0 = z_im;
        b1 = z_im;
        if (state == SETUP) begin
            a0 = DATA_W'(x_q);
            a1 = re_scale_q;
            b0 = DATA_W'(y_q);
            b1 = im_scale_q;
        end
    end

    fxp_mul #(.W(DATA_W)) u_mul_a (.a(a0),   .b(a1),   .p(prod_a));
    fxp_mul #(.W(DATA_W)) u_mul_b (.a(b0),   .b(b1),   .p(prod_b));
    fxp_mul #(.W(DATA_W)) u_mul_c (.a(z_re), .b(z_im), .p(prod_c));

    // Low DATA_W bits of a signed product equal those of the unsigned one,
    // so the truncated pixel offset is exact for any unsigned scale.
    assign c_re_next = re_start_q + prod_a[DATA_W-1:0];
    assign c_im_next = im_start_q + prod_b[DATA_W-1:0];

    assign diff    = prod_a - prod_b;
    assign re_next = diff[FRAC_BITS +: DATA_W] + c_re;
    // Bit window one lower than the shift gives (2*zr*zi) >>> FRAC_BITS
    assign im_next = prod_c[FRAC_BITS-1 +: DATA_W] + c_im;

    assign mag    = {1'b0, prod_a} + {1'b0, prod_b};
    assign escape = mag > ESC_LIM;

    assign unused_bits = ^{diff[W2-1:FRAC_BITS+DATA_W], diff[FRAC_BITS-1:0],
                           prod_c[W2-1:FRAC_BITS+DATA_W-1], prod_c[FRAC_BITS-2:0]};

`ifdef POINT_GENERATOR_BULB_EN
    localparam logic [W2+2:0]        BULB_LIM = (W2+3)'(bulb_limit(FRAC_BITS));
    localparam logic signed [DATA_W:0] ONE_FX = (DATA_W+1)'(1) << FRAC_BITS;

    logic signed [DATA_W:0] b_re, b_im;
    logic signed [W2+1:0]   b_re_sq, b_im_sq;

    // One extra bit keeps c_re+1 from wrapping near the top of the range
    assign b_re = {c_re_next[DATA_W-1], c_re_next} + ONE_FX;
    assign b_im = {c_im_next[DATA_W-1], c_im_next};

    fxp_mul #(.W(DATA_W+1)) u_bulb_re (.a(b_re), .b(b_re), .p(b_re_sq));
    fxp_mul #(.W(DATA_W+1)) u_bulb_im (.a(b_im), .b(b_im), .p(b_im_sq));

    assign in_bulb = ({1'b0, b_re_sq} + {1'b0, b_im_sq}) < BULB_LIM;
`else
    assign in_bulb = 1'b0;
`endif

    always_ff @(posedge CLK or negedge SYS_RESET_N) begin
        if (!SYS_RESET_N) begin
            state      <= IDLE;
            ready      <= 1'b0;
            iteration  <= '0;
            x_q        <= '0;
            y_q        <= '0;
            re_scale_q <= '0;
            im_scale_q <= '0;
            re_start_q <= '0;
            im_start_q <= '0;
            max_q      <= '0;
            c_re       <= '0;
            c_im       <= '0;
            z_re       <= '0;
            z_im       <= '0;
            n          <= '0;
        end else if (start) begin
            x_q        <= x;
            y_q        <= y;
            re_scale_q <= re_scale;
            im_scale_q <= im_scale;
            re_start_q <= re_start;
            im_start_q <= im_start;
            max_q      <= max_iterations;
            ready      <= 1'b0;
            state      <= SETUP;
        end else begin
            case (state)
                SETUP: begin
                    c_re  <= c_re_next;
                    c_im  <= c_im_next;
                    z_re  <= '0;
                    z_im  <= '0;
                    // A bulb hit preloads n so the first check terminates at max
                    n     <= in_bulb ? max_q : '0;
                    state <= ITERATE;
                end
                ITERATE: begin
                    if (n == max_q || escape) begin
                        iteration <= n;
                        ready     <= 1'b1;
                        state     <= DONE;
                    end else begin
                        z_re <= re_next;
                        z_im <= im_next;
                        n    <= n + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_point_generator.sv
// Randomized and directed checks of point_generator against an arithmetic escape-time model.
module tb_point_generator;

    localparam int FRAC = 28;
    localparam logic [64:0] ESC = 65'd4 << (2 * FRAC);
    localparam logic [64:0] BULB = 65'd1 << (2 * FRAC - 4);

    logic        CLK = 1'b0;
    logic        SYS_RESET_N = 1'b0;
    logic        start = 1'b0;
    logic [11:0] x = '0, y = '0;
    logic [31:0] re_scale = '0, im_scale = '0;
    logic signed [31:0] re_start = '0, im_start = '0;
    logic [31:0] max_iterations = '0;
    logic        ready;
    logic [31:0] iteration;

    int checks = 0;
    int errors = 0;
    logic [31:0] held_iter = '0;

    point_generator dut (
        .CLK(CLK), .SYS_RESET_N(SYS_RESET_N), .start(start),
        .x(x), .y(y), .re_scale(re_scale), .im_scale(im_scale),
        .re_start(re_start), .im_start(im_start),
        .max_iterations(max_iterations), .ready(ready), .iteration(iteration)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Escape-time count from the rules: c = start + pixel*scale, z <- z^2 + c.
    function automatic int unsigned ref_iter(input logic [11:0] px, input logic [11:0] py,
                                             input logic [31:0] rs, input logic [31:0] is,
                                             input logic [31:0] r0, input logic [31:0] i0,
                                             input logic [31:0] mx, output bit bulb);
        int cre, cim, zr, zi;
        longint zr2, zi2, zri;
        logic [64:0] mag;
        int unsigned k;
        cre = int'(r0 + 32'(px) * rs);
        cim = int'(i0 + 32'(py) * is);
        bulb = 1'b0;
`ifdef POINT_GENERATOR_BULB_EN
        begin
            longint br;
            br = longint'(cre) + (longint'(1) << FRAC);
            mag = {1'b0, br * br} + {1'b0, longint'(cim) * longint'(cim)};
            if (mag < BULB) begin
                bulb = 1'b1;
                return mx;
            end
        end
`endif
        zr = 0;
        zi = 0;
        k = 0;
        while (1'b1) begin
            zr2 = longint'(zr) * longint'(zr);
            zi2 = longint'(zi) * longint'(zi);
            zri = longint'(zr) * longint'(zi);
            if (k == mx) return k;
            mag = {1'b0, zr2} + {1'b0, zi2};
            if (mag > ESC) return k;
            zr = int'((zr2 - zi2) >>> FRAC) + cre;
            zi = int'((2 * zri) >>> FRAC) + cim;
            k++;
        end
        return k;
    endfunction

    // Drives one start pulse sampled at edge E0 and checks the cycle right after it.
    task automatic launch(input logic [11:0] px, input logic [11:0] py,
                          input logic [31:0] rs, input logic [31:0] is,
                          input logic [31:0] r0, input logic [31:0] i0, input logic [31:0] mx);
        @(negedge CLK);
        x = px; y = py; re_scale = rs; im_scale = is;
        re_start = r0; im_start = i0; max_iterations = mx;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        check("ready_low_after_start", 64'(ready), 64'd0);
        check("iteration_held", 64'(iteration), 64'(held_iter));
    endtask

    // Counts edges from E0 until ready, bounded, then checks latency and count.
    task automatic wait_result(input string tag, input int unsigned exp_n, input int exp_lat);
        int edges;
        edges = 0;
        while (!ready && edges < exp_lat + 20) begin
            @(posedge CLK);
            #1;
            edges++;
        end
        check({tag, "_latency"}, 64'(edges), 64'(exp_lat));
        check({tag, "_iteration"}, 64'(iteration), 64'(exp_n));
        held_iter = iteration;
    endtask

    task automatic run_point(input string tag, input logic [11:0] px, input logic [11:0] py,
                             input logic [31:0] rs, input logic [31:0] is,
                             input logic [31:0] r0, input logic [31:0] i0, input logic [31:0] mx);
        int unsigned en;
        bit bulb;
        en = ref_iter(px, py, rs, is, r0, i0, mx, bulb);
        launch(px, py, rs, is, r0, i0, mx);
        wait_result(tag, en, bulb ? 2 : int'(en) + 2);
    endtask

    initial begin
        logic [31:0] two_fx, m3_fx, m2_fx, step;
        int unsigned en;
        bit bulb;
        two_fx = 32'd2 << FRAC;
        m3_fx  = -(32'd3 << FRAC);
        m2_fx  = -(32'd2 << FRAC);
        step   = 32'((64'd4 << FRAC) / 480);

        #12;
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_iteration", 64'(iteration), 64'd0);
        @(negedge CLK);
        SYS_RESET_N = 1'b1;

        run_point("t1_origin", 12'd0, 12'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd255);
        run_point("t2_c_two", 12'd0, 12'd0, 32'd0, 32'd0, two_fx, 32'd0, 32'd255);
        run_point("t3_far", 12'd0, 12'd0, step, step, m3_fx, m2_fx, 32'd255);
        run_point("t4_max_zero", 12'd7, 12'd9, step, step, 32'd0, 32'd0, 32'd0);

        // Restart mid-iteration: the aborted point must leave no trace
        launch(12'd0, 12'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd255);
        repeat (48) @(posedge CLK);
        en = ref_iter(12'd0, 12'd0, 32'd0, 32'd0, two_fx, 32'd0, 32'd255, bulb);
        launch(12'd0, 12'd0, 32'd0, 32'd0, two_fx, 32'd0, 32'd255);
        wait_result("t5_restart", en, bulb ? 2 : int'(en) + 2);

        // Asynchronous reset in the middle of a long point
        launch(12'd0, 12'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd255);
        repeat (20) @(posedge CLK);
        #3;
        SYS_RESET_N = 1'b0;
        #1;
        check("t6_reset_ready", 64'(ready), 64'd0);
        check("t6_reset_iteration", 64'(iteration), 64'd0);
        @(negedge CLK);
        SYS_RESET_N = 1'b1;
        held_iter = '0;
        begin
            int seen;
            seen = 0;
            repeat (300) begin
                @(posedge CLK);
                #1;
                if (ready) seen++;
            end
            check("t6_no_ready_after_reset", 64'(seen), 64'd0);
        end

        for (int i = 0; i < 24; i++) begin
            logic [11:0] px, py;
            logic [31:0] rs, is, r0, i0, mx;
            px = 12'($urandom_range(0, 4095));
            py = 12'($urandom_range(0, 4095));
            rs = 32'($urandom_range(0, 1 << 18));
            is = 32'($urandom_range(0, 1 << 18));
            r0 = -32'($urandom_range(1 << 27, 5 << 27));
            i0 = -32'($urandom_range(0, 3 << 27));
            mx = 32'($urandom_range(0, 64));
            run_point("rand", px, py, rs, is, r0, i0, mx);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
